// File: rtl/ahb_sram_ws_if.sv
// rtl/ahb_sram_ws_if.sv - AHB-Lite bus bundle between a master/decoder and ahb_sram_ws
interface ahb_sram_ws_if #(
    parameter int P_DATA_WIDTH = 32
);
    logic                    HSEL;
    logic [31:0]             HADDR;
    logic [1:0]              HTRANS;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [2:0]              HBURST;
    logic [P_DATA_WIDTH-1:0] HWDATA;
    logic [P_DATA_WIDTH-1:0] HRDATA;
    logic [1:0]              HRESP;
    logic                    HREADYin;
    logic                    HREADYout;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYin,
        output HRDATA, HRESP, HREADYout
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYin,
        input  HRDATA, HRESP, HREADYout
    );
endinterface

// File: rtl/ahb_sram_ws.sv
// rtl/ahb_sram_ws.sv - AHB-Lite SRAM slave with wait states, byte-lane writes and write-to-read forwarding
// Optional: define AHB_SRAM_RANGE_ERR_EN to ERROR out-of-range and illegal size/alignment accesses.
module ahb_sram_ws #(
    parameter int P_SLV_ID        = 0,
    parameter int P_DATA_WIDTH    = 32,
    parameter int P_SIZE_IN_BYTES = 4096,
    parameter int P_RD_WAIT       = 0,
    parameter int P_WR_WAIT       = 0
) (
    input logic          HCLK,
    input logic          HRESET,
    ahb_sram_ws_if.slave bus
);
    localparam int NB    = P_DATA_WIDTH / 8;
    localparam int LB    = $clog2(NB);
    localparam int DEPTH = P_SIZE_IN_BYTES / NB;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [2:0] MAX_SIZE = 3'(LB);
    localparam logic [3:0] RD_LOAD  = 4'(P_RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD  = 4'(P_WR_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic          dp_valid_q, dp_valid_d;
    logic          dp_write_q, dp_write_d;
    logic          dp_err_q,   dp_err_d;
    logic [AW-1:0] dp_addr_q,  dp_addr_d;
    logic [NB-1:0] dp_lanes_q, dp_lanes_d;

    logic [P_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [P_DATA_WIDTH-1:0] mem [DEPTH];

    logic          hready;
    logic          resp_err;
    logic          accept;
    logic          a_illegal;
    logic          a_err;
    logic [LB-1:0] a_off;
    logic [LB-1:0] a_align;
    logic [NB-1:0] a_lanes;
    logic [AW-1:0] a_addr;

    logic                    commit;
    logic                    rd_now;
    logic [AW-1:0]           rd_addr;
    logic [P_DATA_WIDTH-1:0] old_word;
    logic [P_DATA_WIDTH-1:0] merged;

    logic unused_ok;
    assign unused_ok = ^{bus.HBURST, bus.HADDR, 32'(P_SLV_ID)};

    // Address-phase decode: a_align masks the offset bits that must be zero for HSIZE.
    assign a_off  = bus.HADDR[LB-1:0];
    assign a_addr = bus.HADDR[LB+AW-1:LB];
    assign accept = bus.HSEL && bus.HREADYin && bus.HTRANS[1] && hready;

    always_comb begin
        a_align = '0;
        a_lanes = '0;
        for (int b = 0; b < LB; b++) begin
            a_align[b] = (3'(b) < bus.HSIZE);
        end
        a_illegal = (bus.HSIZE > MAX_SIZE) || ((a_off & a_align) != '0);
        for (int b = 0; b < NB; b++) begin
            a_lanes[b] = !a_illegal && ((LB'(b) & ~a_align) == (a_off & ~a_align));
        end
    end

`ifdef AHB_SRAM_RANGE_ERR_EN
    assign a_err = a_illegal || (bus.HADDR >= 32'(P_SIZE_IN_BYTES));
`else
    assign a_err = 1'b0;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_err_q   <= 1'b0;
            dp_addr_q  <= '0;
            dp_lanes_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_err_q   <= dp_err_d;
            dp_addr_q  <= dp_addr_d;
            dp_lanes_q <= dp_lanes_d;
            rdata_q    <= rdata_d;
        end
    end

    // ERR2 completes its data phase with HREADYout high, so it may accept like IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_ERR2: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (a_err) begin
                        state_d = S_ERR1;
                    end else if (!bus.HWRITE && (P_RD_WAIT > 0)) begin
                        state_d = S_RD_WAIT;
                        cnt_d   = RD_LOAD;
                    end else if (bus.HWRITE && (P_WR_WAIT > 0)) begin
                        state_d = S_WR_WAIT;
                        cnt_d   = WR_LOAD;
                    end
                end
            end
            S_RD_WAIT, S_WR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hready   = 1'b1;
        resp_err = 1'b0;
        case (state_q)
            S_RD_WAIT, S_WR_WAIT: hready = 1'b0;
            S_ERR1: begin
                hready   = 1'b0;
                resp_err = 1'b1;
            end
            S_ERR2:  resp_err = 1'b1;
            default: ;
        endcase
    end

    assign bus.HREADYout = hready;
    assign bus.HRESP     = {1'b0, resp_err};
    assign bus.HRDATA    = rdata_q;

    // Data-phase attributes advance only when the current data phase completes.
    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_err_d   = dp_err_q;
        dp_addr_d  = dp_addr_q;
        dp_lanes_d = dp_lanes_q;
        if (hready) begin
            dp_valid_d = accept;
            dp_write_d = bus.HWRITE;
            dp_err_d   = a_err;
            dp_addr_d  = a_addr;
            dp_lanes_d = a_lanes;
        end
    end

    assign commit  = hready && dp_valid_q && dp_write_q && !dp_err_q;
    assign rd_now  = (accept && !bus.HWRITE && !a_err && (P_RD_WAIT == 0)) ||
                     ((state_q == S_RD_WAIT) && (cnt_q == '0));
    assign rd_addr = (state_q == S_RD_WAIT) ? dp_addr_q : a_addr;

    always_comb begin
        old_word = mem[dp_addr_q];
        merged   = old_word;
        for (int b = 0; b < NB; b++) begin
            if (dp_lanes_q[b]) begin
                merged[8*b +: 8] = bus.HWDATA[8*b +: 8];
            end
        end
    end

    // A commit landing on the same edge as the array read of the same word is forwarded.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_now) begin
            if (commit && (dp_addr_q == rd_addr)) begin
                rdata_d = merged;
            end else begin
                rdata_d = mem[rd_addr];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            mem[dp_addr_q] <= merged;
        end
    end
endmodule

// File: tb/tb_ahb_sram_ws.sv
// tb/tb_ahb_sram_ws.sv - directed table-driven bench for ahb_sram_ws (32-bit zero-wait and 64-bit waited instances)
module tb_ahb_sram_ws;
`ifdef AHB_SRAM_RANGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [1:0] RSP_OK = 2'b00;
    localparam logic [1:0] RSP_EA = ERR_EN ? 2'b01 : 2'b00;
    localparam int         WAIT_E = ERR_EN ? 1 : 0;

    typedef struct {
        bit          sel;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [63:0] exp_data;
        bit          chk_data;
        logic [1:0]  exp_resp;
        int          exp_waits;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        tsel;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [63:0] hwdata;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    ahb_sram_ws_if #(.P_DATA_WIDTH(32)) ifa ();
    ahb_sram_ws_if #(.P_DATA_WIDTH(64)) ifb ();

    assign ifa.HSEL     = hsel & ~tsel;
    assign ifa.HADDR    = haddr;
    assign ifa.HTRANS   = htrans;
    assign ifa.HWRITE   = hwrite;
    assign ifa.HSIZE    = hsize;
    assign ifa.HBURST   = 3'b000;
    assign ifa.HWDATA   = hwdata[31:0];
    assign ifa.HREADYin = ifa.HREADYout;

    assign ifb.HSEL     = hsel & tsel;
    assign ifb.HADDR    = haddr;
    assign ifb.HTRANS   = htrans;
    assign ifb.HWRITE   = hwrite;
    assign ifb.HSIZE    = hsize;
    assign ifb.HBURST   = 3'b000;
    assign ifb.HWDATA   = hwdata;
    assign ifb.HREADYin = ifb.HREADYout;

    ahb_sram_ws #(
        .P_SLV_ID(0), .P_DATA_WIDTH(32), .P_SIZE_IN_BYTES(4096), .P_RD_WAIT(0), .P_WR_WAIT(0)
    ) u_a (
        .HCLK(clk), .HRESET(rst), .bus(ifa)
    );

    ahb_sram_ws #(
        .P_SLV_ID(1), .P_DATA_WIDTH(64), .P_SIZE_IN_BYTES(4096), .P_RD_WAIT(3), .P_WR_WAIT(1)
    ) u_b (
        .HCLK(clk), .HRESET(rst), .bus(ifb)
    );

    wire        cur_ready = tsel ? ifb.HREADYout : ifa.HREADYout;
    wire [1:0]  cur_resp  = tsel ? ifb.HRESP : ifa.HRESP;
    wire [63:0] cur_rdata = tsel ? ifb.HRDATA : {32'h0, ifa.HRDATA};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input bit s, input bit w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [63:0] wd, input logic [63:0] ed, input bit cd,
                       input logic [1:0] er, input int ew);
        vec_t v;
        v.sel = s; v.wr = w; v.addr = a; v.size = sz; v.wdata = wd;
        v.exp_data = ed; v.chk_data = cd; v.exp_resp = er; v.exp_waits = ew;
        tbl.push_back(v);
    endtask

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic drive_addr(input bit w, input logic [31:0] a, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = w;
        haddr  = a;
        hsize  = sz;
    endtask

    // Returns at the negedge where the selected slave shows HREADYout high.
    task automatic wait_ready(output int w, output logic [63:0] rd, output logic [1:0] rsp);
        bit done;
        w    = 0;
        done = 1'b0;
        while (!done && w < 40) begin
            @(negedge clk);
            if (cur_ready) done = 1'b1;
            else w++;
        end
        rd  = cur_rdata;
        rsp = cur_resp;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL ready_timeout actual=low required=high");
        end
    endtask

    task automatic xfer(input vec_t v, output int w, output logic [63:0] rd, output logic [1:0] rsp);
        @(negedge clk);
        tsel = v.sel;
        drive_addr(v.wr, v.addr, v.size);
        @(posedge clk);
        #1;
        drive_idle();
        hwdata = v.wdata;
        wait_ready(w, rd, rsp);
    endtask

    // Write followed by a read of the same word, accepted in the write's last data-phase cycle.
    task automatic wr_rd(input bit s, input logic [31:0] a, input logic [2:0] sz, input logic [63:0] wd,
                         output int ww, output int rw, output logic [63:0] rd);
        logic [63:0] dummy;
        logic [1:0]  rsp;
        @(negedge clk);
        tsel = s;
        drive_addr(1'b1, a, sz);
        @(posedge clk);
        #1;
        drive_idle();
        hwdata = wd;
        wait_ready(ww, dummy, rsp);
        drive_addr(1'b0, a, sz);
        @(posedge clk);
        #1;
        drive_idle();
        wait_ready(rw, rd, rsp);
    endtask

    initial begin
        int          w;
        int          ww;
        int          rw;
        logic [63:0] rd;
        logic [1:0]  rsp;
        vec_t        v;

        rst = 1'b1; tsel = 1'b0; hwrite = 1'b0; haddr = '0; hsize = '0; hwdata = '0;
        drive_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_a_ready", 64'(ifa.HREADYout), 64'd1);
        chk("rst_a_resp",  64'(ifa.HRESP),     64'd0);
        chk("rst_a_rdata", 64'(ifa.HRDATA),    64'd0);
        chk("rst_b_ready", 64'(ifb.HREADYout), 64'd1);
        chk("rst_b_resp",  64'(ifb.HRESP),     64'd0);
        chk("rst_b_rdata", ifb.HRDATA,         64'd0);

        // 32-bit, zero wait
        add(0, 1, 32'h10,   3'd2, 64'hDEADBEEF, 64'h0,        0, RSP_OK, 0);
        add(0, 0, 32'h10,   3'd2, 64'h0,        64'hDEADBEEF, 1, RSP_OK, 0);
        add(0, 1, 32'h11,   3'd0, 64'h00005500, 64'h0,        0, RSP_OK, 0);
        add(0, 0, 32'h10,   3'd2, 64'h0,        64'hDEAD55EF, 1, RSP_OK, 0);
        add(0, 1, 32'h12,   3'd1, 64'h12340000, 64'h0,        0, RSP_OK, 0);
        add(0, 0, 32'h10,   3'd2, 64'h0,        64'h123455EF, 1, RSP_OK, 0);
        add(0, 1, 32'h0,    3'd2, 64'h11111111, 64'h0,        0, RSP_OK, 0);
        add(0, 1, 32'h2,    3'd2, 64'hFFFFFFFF, 64'h0,        0, RSP_EA, WAIT_E);
        add(0, 0, 32'h0,    3'd2, 64'h0,        64'h11111111, 1, RSP_OK, 0);
        add(0, 1, 32'h1000, 3'd2, 64'h00000055, 64'h0,        0, RSP_EA, WAIT_E);
        add(0, 0, 32'h0,    3'd2, 64'h0, ERR_EN ? 64'h11111111 : 64'h55, 1, RSP_OK, 0);
        add(0, 1, 32'h4,    3'd2, 64'hCAFEF00D, 64'h0,        0, RSP_OK, 0);
        add(0, 1, 32'h1004, 3'd2, 64'h00001234, 64'h0,        0, RSP_EA, WAIT_E);
        add(0, 0, 32'h4,    3'd2, 64'h0, ERR_EN ? 64'hCAFEF00D : 64'h1234, 1, RSP_OK, 0);
        add(0, 0, 32'h1000, 3'd2, 64'h0, ERR_EN ? 64'hCAFEF00D : 64'h55, 1, RSP_EA, WAIT_E);
        add(0, 1, 32'h13,   3'd1, 64'hFFFF0000, 64'h0,        0, RSP_EA, WAIT_E);
        add(0, 0, 32'h11,   3'd0, 64'h0,        64'h123455EF, 1, RSP_OK, 0);
        // 64-bit, 3 read / 1 write wait states
        add(1, 1, 32'h10, 3'd3, 64'h0,                   64'h0,                   0, RSP_OK, 1);
        add(1, 1, 32'h13, 3'd0, 64'h00000000_AA000000,   64'h0,                   0, RSP_OK, 1);
        add(1, 0, 32'h10, 3'd3, 64'h0,                   64'h00000000_AA000000,   1, RSP_OK, 3);
        add(1, 1, 32'h16, 3'd1, 64'hBEEF0000_00000000,   64'h0,                   0, RSP_OK, 1);
        add(1, 0, 32'h10, 3'd3, 64'h0,                   64'hBEEF0000_AA000000,   1, RSP_OK, 3);
        add(1, 1, 32'h20, 3'd3, 64'h01234567_89ABCDEF,   64'h0,                   0, RSP_OK, 1);
        add(1, 1, 32'h24, 3'd2, 64'h55555555_00000000,   64'h0,                   0, RSP_OK, 1);
        add(1, 0, 32'h20, 3'd3, 64'h0,                   64'h55555555_89ABCDEF,   1, RSP_OK, 3);
        add(1, 1, 32'h24, 3'd3, 64'hFFFFFFFF_FFFFFFFF,   64'h0,                   0, RSP_EA, 1);
        add(1, 0, 32'h20, 3'd3, 64'h0,                   64'h55555555_89ABCDEF,   1, RSP_OK, 3);

        foreach (tbl[i]) begin
            v = tbl[i];
            xfer(v, w, rd, rsp);
            chk($sformatf("vec%0d_resp", i),  64'(rsp), 64'(v.exp_resp));
            chk($sformatf("vec%0d_waits", i), 64'(w),   64'(v.exp_waits));
            if (v.chk_data) chk($sformatf("vec%0d_rdata", i), rd, v.exp_data);
        end

        // Back-to-back write/read of one word on the zero-wait slave exercises forwarding.
        v = '{sel: 0, wr: 1, addr: 32'h40, size: 3'd2, wdata: 64'h0, exp_data: 64'h0,
              chk_data: 0, exp_resp: RSP_OK, exp_waits: 0};
        xfer(v, w, rd, rsp);
        wr_rd(1'b0, 32'h40, 3'd2, 64'hDEADBEEF, ww, rw, rd);
        chk("fwd_word_wwait", 64'(ww), 64'd0);
        chk("fwd_word_rwait", 64'(rw), 64'd0);
        chk("fwd_word_rdata", rd, 64'hDEADBEEF);
        wr_rd(1'b0, 32'h41, 3'd0, 64'h00007700, ww, rw, rd);
        chk("fwd_byte_rdata", rd, 64'hDEAD77EF);

        wr_rd(1'b1, 32'h30, 3'd3, 64'h11112222_33334444, ww, rw, rd);
        chk("raw_b_wwait", 64'(ww), 64'd1);
        chk("raw_b_rwait", 64'(rw), 64'd3);
        chk("raw_b_rdata", rd, 64'h11112222_33334444);

        // Reset while the 64-bit slave is inserting read wait states.
        @(negedge clk);
        tsel = 1'b1;
        drive_addr(1'b0, 32'h10, 3'd3);
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        chk("rstmid_pre_ready", 64'(ifb.HREADYout), 64'd0);
        rst = 1'b1;
        #1;
        chk("rstmid_ready", 64'(ifb.HREADYout), 64'd1);
        chk("rstmid_resp",  64'(ifb.HRESP),     64'd0);
        chk("rstmid_rdata", ifb.HRDATA,         64'd0);
        @(negedge clk);
        rst = 1'b0;
        v = '{sel: 1, wr: 0, addr: 32'h10, size: 3'd3, wdata: 64'h0, exp_data: 64'h0,
              chk_data: 1, exp_resp: RSP_OK, exp_waits: 3};
        xfer(v, w, rd, rsp);
        chk("post_rst_waits", 64'(w), 64'd3);
        chk("post_rst_resp",  64'(rsp), 64'd0);
        chk("post_rst_rdata", rd, 64'hBEEF0000_AA000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
